// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - in-order instruction fetch queue with redirect flush; FETCH_QUEUE_BYPASS_EN enables same-cycle response bypass
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        clk,
    input  logic        rst,
    output logic        req_valid,
    input  logic        req_ready,
    output logic [63:0] req_addr,
    input  logic        rsp_valid,
    input  logic [31:0] rsp_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [63:0] out_pc,
    input  logic        redirect,
    input  logic [63:0] redirect_pc
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] C_ONE   = 1;
    localparam logic [CW-1:0] C_ZERO  = 0;
    localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);
    localparam logic [PW-1:0] P_ONE   = 1;

    logic [63:0]   fpc_q, fpc_d;
    logic [63:0]   rpc_q, rpc_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] inflight_q, inflight_d;
    logic [CW-1:0] drop_q, drop_d;
    logic          started_q, started_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [31:0]   instr_mem_q [DEPTH];
    logic [63:0]   pc_mem_q    [DEPTH];

    logic req_hs;
    logic rsp_ok;
    logic rsp_accept;
    logic bypass;
    logic bypass_take;
    logic push;
    logic pop;

    // Credit check: queue slots plus outstanding requests never exceed DEPTH,
    // so a non-back-pressurable response always has a slot waiting for it.
    assign req_valid = started_q &&
                       (({1'b0, count_q} + {1'b0, inflight_q}) < {1'b0, C_DEPTH});
    assign req_addr  = fpc_q;

`ifdef FETCH_QUEUE_BYPASS_EN
    assign bypass = rsp_ok && (count_q == C_ZERO) && (drop_q == C_ZERO) && !redirect;
`else
    assign bypass = 1'b0;
`endif

    assign out_valid = (count_q != C_ZERO) || bypass;
    assign out_instr = bypass ? rsp_data : instr_mem_q[rd_ptr_q];
    assign out_pc    = bypass ? rpc_q    : pc_mem_q[rd_ptr_q];

    // Next-state: request/response bookkeeping, then redirect overrides everything.
    always_comb begin
        req_hs      = req_valid && req_ready;
        rsp_ok      = rsp_valid && (inflight_q != C_ZERO);
        rsp_accept  = rsp_ok && !redirect && (drop_q == C_ZERO);
        bypass_take = bypass && out_ready;
        push        = rsp_accept && !bypass_take;
        pop         = (count_q != C_ZERO) && out_ready;

        started_d  = 1'b1;
        fpc_d      = req_hs ? fpc_q + 64'd4 : fpc_q;
        rpc_d      = rsp_accept ? rpc_q + 64'd4 : rpc_q;
        inflight_d = inflight_q + (req_hs ? C_ONE : C_ZERO) - (rsp_ok ? C_ONE : C_ZERO);
        drop_d     = (rsp_ok && (drop_q != C_ZERO)) ? drop_q - C_ONE : drop_q;
        count_d    = count_q + (push ? C_ONE : C_ZERO) - (pop ? C_ONE : C_ZERO);
        wr_ptr_d   = push ? wr_ptr_q + P_ONE : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + P_ONE : rd_ptr_q;

        if (redirect) begin
            fpc_d    = {redirect_pc[63:2], 2'b00};
            rpc_d    = {redirect_pc[63:2], 2'b00};
            drop_d   = inflight_d;
            count_d  = C_ZERO;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end
    end

    // State registers and queue storage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fpc_q      <= RESET_PC;
            rpc_q      <= RESET_PC;
            count_q    <= C_ZERO;
            inflight_q <= C_ZERO;
            drop_q     <= C_ZERO;
            started_q  <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                instr_mem_q[i] <= 32'h0;
                pc_mem_q[i]    <= RESET_PC;
            end
        end else begin
            fpc_q      <= fpc_d;
            rpc_q      <= rpc_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
            started_q  <= started_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            if (push) begin
                instr_mem_q[wr_ptr_q] <= rsp_data;
                pc_mem_q[wr_ptr_q]    <= rpc_q;
            end
        end
    end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction fetch front end for the single-cycle RV64 core. Issues sequential 64-bit fetch addresses to a variable-latency instruction memory over a valid/ready request channel, captures in-order 32-bit responses into a small FIFO tagged with their PC, and presents one instruction at a time to decode. A redirect from branch resolution flushes the queue and discards in-flight responses.

## Interface
- `DEPTH`, 4: queue entries and maximum in-flight requests; power of two, ≥2.
- `RESET_PC`, 64'h0: first fetch address after reset.

- `clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `req_valid`  out  1  fetch request valid.
- `req_ready`  in  1  memory accepts request.
- `req_addr`  out  64  fetch address, always 4-byte aligned.
- `rsp_valid`  in  1  one in-order response this cycle; cannot be back-pressured.
- `rsp_data`  in  32  instruction word.
- `out_valid`  out  1  instruction available to decode.
- `out_ready`  in  1  decode consumes instruction.
- `out_instr`  out  32  head instruction.
- `out_pc`  out  64  PC of head instruction.
- `redirect`  in  1  flush and restart fetch.
- `redirect_pc`  in  64  new fetch address; bits [1:0] ignored (treated as 0).

## Operation
- State: `fpc` (next request address), `rpc` (PC of next accepted response), `count` (0..DEPTH queue occupancy), `inflight` (accepted requests without response, 0..DEPTH), `drop` (responses still to discard, ≤ inflight), `started` flag.
- Request: `req_valid = started && (count + inflight < DEPTH)`; `req_addr = fpc`. Handshake = `req_valid && req_ready` -> `fpc += 4`, `inflight += 1`. Credit rule guarantees no response is ever lost to a full queue.
- Response: on `rsp_valid`, `inflight -= 1`. If `drop > 0`: `drop -= 1`, data discarded. Else push {`rsp_data`, `rpc`}, `rpc += 4`.
- Output: head entry shown on `out_instr`/`out_pc` while `out_valid = (count != 0)`. Pop on `out_valid && out_ready`.
- Push and pop in the same cycle: `count` unchanged. Pointers wrap modulo DEPTH; 64-bit PC adds wrap modulo 2^64.
- Redirect (highest priority): next state `count = 0`, `fpc = rpc = redirect_pc & ~3`, `drop = inflight_next`, where `inflight_next` includes a request handshaking this cycle and excludes a response arriving this cycle. A response arriving in the redirect cycle is discarded regardless of `drop`. A pop in the redirect cycle is legal and completes.
- `rsp_valid` with `inflight == 0` is a protocol error; ignored, with no state change.

## Timing
- Reset (`rst` low, asynchronous): `count = inflight = drop = 0`, `fpc = rpc = RESET_PC`, `started = 0`. Outputs: `req_valid = 0`, `req_addr = RESET_PC`, `out_valid = 0`, `out_instr = 0`, `out_pc = RESET_PC`.
- `started` sets on the first rising edge after `rst` deasserts; `req_valid` is first asserted in the second cycle after release.
- Response at edge t is visible on `out_*` from cycle t+1 (one-cycle latency, no bypass).
- Sustained throughput is 1 instr/cycle when memory latency ≤ DEPTH−1 and `out_ready` is held high.
- `out_*` and `req_*` depend only on registered state. There is no combinational path from `redirect`, `rsp_*`, or `out_ready`, except as stated under Configuration.
- `rst` asserted mid-operation: immediate return to reset values. In-flight responses after release are not dropped (memory is reset with the core).

## Configuration
- `FETCH_QUEUE_BYPASS_EN` defined: when `count == 0`, no drop is pending, and no redirect is active, an arriving response drives `out_valid`/`out_instr`/`out_pc` combinationally in the same cycle. If `out_ready` is also high, it is consumed without being written.
- Not defined: no bypass. Behaviour is as in Timing, with strictly registered outputs.

## Test plan
- Reset release, memory with 1-cycle latency, `out_ready = 1`: requests 0x0, 0x4, 0x8… are issued; `out_pc` sequence is 0x0, 0x4, 0x8; one instruction per cycle after fill.
- `out_ready = 0`, DEPTH = 4: exactly 4 requests accepted, then `req_valid = 0`. `count` reaches 4 with no overflow; releasing `out_ready` drains in order.
- 3 requests outstanding, `redirect = 1`, `redirect_pc = 0x1003`: the 3 late responses are discarded, the next request is 0x1000, and the first `out_pc` is 0x1000.
- Redirect in the same cycle as a request handshake and a response: the response is discarded, the handshaken request is dropped later, and `out_valid` stays 0 until the 0x1000 data arrives.
- `req_ready` toggled randomly, latency 1–3: `out_pc` increments by exactly 4 per instruction with no gaps or duplicates.
- Assert `rst` with `count = 2`: `out_valid` and `req_valid` go to 0 immediately. With the bypass macro, the first response on an empty queue appears on `out_instr` in the same cycle.
